axis_downsizer: RTL and testbench
=================================

Name: axis_downsizer

Overview:
- AXI-Stream width down-converter: accepts one UP_WIDTH word per handshake and emits RATIO narrower beats, least-significant lane first.
- Supports a partial final word: on tlast words, only the lanes indicated by up_tlanes are emitted.
- Sits upstream of skid_buffer; dn_* connects directly to that block's up_* port.

Parameters:
- UP_WIDTH, 32, upstream data width in bits; must equal RATIO*DN_WIDTH.
- RATIO, 4, lanes per upstream word; integer >= 2.
- DN_WIDTH, UP_WIDTH/RATIO, downstream beat width; derived, do not override.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- up_tdata  input  UP_WIDTH  wide word; lane k = bits [k*DN_WIDTH +: DN_WIDTH].
- up_tlanes  input  $clog2(RATIO)  on tlast words: number of valid lanes minus 1; ignored when up_tlast=0.
- up_tlast  input  1  end of packet.
- up_tvalid  input  1  upstream valid.
- up_tready  output  1  upstream ready.
- dn_tdata  output  DN_WIDTH  narrow beat.
- dn_tlast  output  1  final beat of packet.
- dn_tvalid  output  1  downstream valid.
- dn_tready  input  1  downstream ready.

Behaviour:
- Storage:
  - Holding register for the word, its tlast flag and its final-lane index.
  - Lane counter `lane`, width $clog2(RATIO).
  - State `busy`.
- State IDLE (busy=0):
  - up_tready=1.
  - On up_tvalid: capture the word, set lane=0, compute final = up_tlast ? up_tlanes : RATIO-1, and go to SEND.
- State SEND (busy=1):
  - dn_tvalid=1 and dn_tdata = lane `lane` of the held word.
  - dn_tlast = held_tlast & (lane==final).
- Beat transfer: dn_tvalid & dn_tready.
  - On a transfer with lane!=final: lane increments.
  - On a transfer with lane==final: the word is done.
- up_tready = ~busy | (lane==final & dn_tready).
  - This is a combinational path from dn_tready, chosen to give zero-bubble back-to-back words.
  - It is acceptable because skid_buffer registers its up_tready.
- Word done with up_tvalid high: load the new word in the same cycle; stay in SEND with lane=0. No idle cycle between words.
- Word done with up_tvalid low: return to IDLE; dn_tvalid deasserts the next cycle.
- Latency: the first beat is valid 1 cycle after the upstream handshake.
- Throughput: RATIO dn beats per full word. A final word with up_tlanes=n takes n+1 beats.
- Stall: while dn_tvalid & ~dn_tready, dn_tdata, dn_tlast and lane hold stable. This is an AXI-S requirement.
- up_tlanes > RATIO-1 is impossible by width when RATIO is a power of two. For non-power-of-two RATIO, clamp final to RATIO-1.
- Reset (async, any time including mid-word):
  - busy=0, lane=0, dn_tvalid=0, dn_tlast=0, dn_tdata=0, holding register cleared.
  - up_tready=0 while rst is asserted.
  - A partially emitted word is discarded.
- Lane ordering is fixed LSB-first; no endian parameter.
- Counter wrap: lane never exceeds final; on word completion it resets to 0 rather than wrapping.

Decomposition:
- Shared package `axis_pkg`:
  - function `lane_w(RATIO)` returning $clog2 with a minimum of 1.
  - elaboration-time check macro: UP_WIDTH % RATIO == 0 and RATIO >= 2.
- No sub-module: a single always_ff for state, counter and holding register, plus combinational output muxing.
- Output registering is delegated to a downstream skid_buffer at integration.

Test Plan:
- Single full word, RATIO=4, UP_WIDTH=32: up_tdata=32'hDDCCBBAA, tlast=0, dn_tready=1 -> dn beats AA,BB,CC,DD on consecutive cycles starting 1 cycle after the handshake; dn_tlast=0 throughout.
- Partial final word: 32'h44332211, tlast=1, tlanes=1 -> beats 11,22; dn_tlast=1 on 22 only; IDLE afterwards.
- Back-to-back: two words offered continuously with dn_tready=1 -> 8 contiguous dn beats with no bubble; up_tready high exactly on cycles 0 and 4.
- Downstream stall: dn_tready=0 for 3 cycles while lane=2 -> dn_tdata stays CC and up_tready stays 0; CC transfers when ready returns, then DD.
- Async reset mid-word: assert rst between clock edges after beat BB -> dn_tvalid drops immediately, without waiting for a clock edge. After release, the next word starts at lane 0.
- Random: random up_tvalid/dn_tready (50%) and random tlast/tlanes over 1000 words -> scoreboard concatenation matches; dn_tlast count equals the up_tlast count.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream width converters: FSM states,
// lane-index width helper and an elaboration-time parameter check.
`timescale 1ns/1ps
package axis_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Lane index width; never below 1 so single-bit counters stay legal.
   function automatic int lane_w(input int ratio);
      int w;
      w = $clog2(ratio);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`define AXIS_PARAM_CHECK(up_w, ratio) \
   if ((((up_w) % (ratio)) != 0) || ((ratio) < 2)) begin : g_param_check \
      $error("axis: UP_WIDTH must be a multiple of RATIO and RATIO must be >= 2"); \
   end

// File: rtl/axis_downsizer.sv
// AXI-Stream width down-converter: one UP_WIDTH word in, RATIO narrow beats
// out (LSB lane first), with a partial final word on tlast.
`timescale 1ns/1ps
module axis_downsizer
   import axis_pkg::*;
#(
   parameter int UP_WIDTH = 32,
   parameter int RATIO    = 4,
   parameter int DN_WIDTH = UP_WIDTH / RATIO
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [UP_WIDTH-1:0]                  up_tdata,
   input  logic [axis_pkg::lane_w(RATIO)-1:0]   up_tlanes,
   input  logic                                 up_tlast,
   input  logic                                 up_tvalid,
   output logic                                 up_tready,
   output logic [DN_WIDTH-1:0]                  dn_tdata,
   output logic                                 dn_tlast,
   output logic                                 dn_tvalid,
   input  logic                                 dn_tready
);

   localparam int                LANE_W    = lane_w(RATIO);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   `AXIS_PARAM_CHECK(UP_WIDTH, RATIO)

   // Handshake: a transfer happens on any clock edge where valid & ready are
   // both high; valid never waits on ready, and a stalled beat holds stable.
   state_t              state_q;
   logic [UP_WIDTH-1:0] word_q;
   logic                tlast_q;
   logic [LANE_W-1:0]   final_q;
   logic [LANE_W-1:0]   lane_q;
   logic [LANE_W-1:0]   final_d;
   logic                busy;
   logic                lane_done;
   logic                load;

   assign busy      = (state_q == ST_SEND);
   assign lane_done = (lane_q == final_q);

   // Non-power-of-two ratios can encode lane counts past the last lane.
   always_comb begin
      final_d = LAST_LANE;
      if (up_tlast) begin
         final_d = (up_tlanes > LAST_LANE) ? LAST_LANE : up_tlanes;
      end
   end

   // Combinational through dn_tready so back-to-back words have no bubble.
   assign up_tready = ~rst & (~busy | (lane_done & dn_tready));
   assign load      = up_tvalid & up_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         tlast_q <= 1'b0;
         final_q <= '0;
         lane_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  word_q  <= up_tdata;
                  tlast_q <= up_tlast;
                  final_q <= final_d;
                  lane_q  <= '0;
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (dn_tready) begin
                  if (!lane_done) begin
                     lane_q <= lane_q + LANE_W'(1);
                  end else if (load) begin
                     word_q  <= up_tdata;
                     tlast_q <= up_tlast;
                     final_q <= final_d;
                     lane_q  <= '0;
                  end else begin
                     lane_q  <= '0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dn_tdata = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (busy && (lane_q == LANE_W'(k))) begin
            dn_tdata = word_q[k*DN_WIDTH +: DN_WIDTH];
         end
      end
   end

   assign dn_tvalid = busy;
   assign dn_tlast  = busy & tlast_q & lane_done;

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed and randomised checks of axis_downsizer with RATIO=4, 32->8 bits.
`timescale 1ns/1ps
module tb_axis_downsizer;

   logic        clk;
   logic        rst;
   logic [31:0] up_tdata;
   logic [1:0]  up_tlanes;
   logic        up_tlast;
   logic        up_tvalid;
   logic        up_tready;
   logic [7:0]  dn_tdata;
   logic        dn_tlast;
   logic        dn_tvalid;
   logic        dn_tready;

   int checks   = 0;
   int failures = 0;

   // {tlast, data} of every beat still owed by the DUT.
   logic [8:0] exp_q [$];

   axis_downsizer #(
      .UP_WIDTH (32),
      .RATIO    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .up_tdata  (up_tdata),
      .up_tlanes (up_tlanes),
      .up_tlast  (up_tlast),
      .up_tvalid (up_tvalid),
      .up_tready (up_tready),
      .dn_tdata  (dn_tdata),
      .dn_tlast  (dn_tlast),
      .dn_tvalid (dn_tvalid),
      .dn_tready (dn_tready)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      rst       = 1'b1;
      up_tdata  = 32'h0;
      up_tlanes = 2'd0;
      up_tlast  = 1'b0;
      up_tvalid = 1'b0;
      dn_tready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      up_tvalid = 1'b1;
      #1;
      checks++;
      if (up_tready !== 1'b0) begin
         failures++;
         $display("FAIL reset_up_tready: got %b expected 0", up_tready);
      end
      checks++;
      if (dn_tvalid !== 1'b0 || dn_tlast !== 1'b0 || dn_tdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b last=%b data=%h expected 0/0/00",
                  dn_tvalid, dn_tlast, dn_tdata);
      end
      @(negedge clk);
      up_tvalid = 1'b0;
      rst       = 1'b0;
      #1;
      checks++;
      if (up_tready !== 1'b1 || dn_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got up_tready=%b dn_tvalid=%b expected 1/0",
                  up_tready, dn_tvalid);
      end
   endtask

   task automatic test_full_word();
      logic [7:0] exp_b [4];
      exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      @(negedge clk);
      up_tdata  = 32'hDDCCBBAA;
      up_tlast  = 1'b0;
      up_tlanes = 2'd0;
      up_tvalid = 1'b1;
      dn_tready = 1'b1;
      #1;
      checks++;
      if (up_tready !== 1'b1 || dn_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL full_handshake: got up_tready=%b dn_tvalid=%b expected 1/0",
                  up_tready, dn_tvalid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         up_tvalid = 1'b0;
         #1;
         checks++;
         if (dn_tvalid !== 1'b1 || dn_tdata !== exp_b[i] || dn_tlast !== 1'b0) begin
            failures++;
            $display("FAIL full_beat%0d: got valid=%b data=%h last=%b expected 1/%h/0",
                     i, dn_tvalid, dn_tdata, dn_tlast, exp_b[i]);
         end
         checks++;
         if (up_tready !== (i == 3)) begin
            failures++;
            $display("FAIL full_ready%0d: got up_tready=%b expected %b", i, up_tready, (i == 3));
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (dn_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL full_idle: got dn_tvalid=%b expected 0", dn_tvalid);
      end
   endtask

   task automatic test_partial();
      logic [7:0] exp_b [2];
      exp_b = '{8'h11, 8'h22};
      @(negedge clk);
      up_tdata  = 32'h44332211;
      up_tlast  = 1'b1;
      up_tlanes = 2'd1;
      up_tvalid = 1'b1;
      dn_tready = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         up_tvalid = 1'b0;
         up_tlast  = 1'b0;
         #1;
         checks++;
         if (dn_tvalid !== 1'b1 || dn_tdata !== exp_b[i] || dn_tlast !== (i == 1)) begin
            failures++;
            $display("FAIL partial_beat%0d: got valid=%b data=%h last=%b expected 1/%h/%b",
                     i, dn_tvalid, dn_tdata, dn_tlast, exp_b[i], (i == 1));
         end
         checks++;
         if (up_tready !== (i == 1)) begin
            failures++;
            $display("FAIL partial_ready%0d: got up_tready=%b expected %b", i, up_tready, (i == 1));
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (dn_tvalid !== 1'b0 || up_tready !== 1'b1) begin
         failures++;
         $display("FAIL partial_idle: got dn_tvalid=%b up_tready=%b expected 0/1",
                  dn_tvalid, up_tready);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [8];
      exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88};
      dn_tready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 0) begin
            up_tdata  = 32'hDDCCBBAA;
            up_tlast  = 1'b0;
            up_tlanes = 2'd0;
            up_tvalid = 1'b1;
         end else if (c <= 4) begin
            up_tdata  = 32'h88776655;
            up_tlast  = 1'b1;
            up_tlanes = 2'd3;
            up_tvalid = 1'b1;
         end else begin
            up_tvalid = 1'b0;
            up_tlast  = 1'b0;
         end
         #1;
         if (c < 8) begin
            checks++;
            if (up_tready !== ((c == 0) || (c == 4))) begin
               failures++;
               $display("FAIL b2b_ready_c%0d: got up_tready=%b expected %b",
                        c, up_tready, ((c == 0) || (c == 4)));
            end
         end
         if (c >= 1) begin
            checks++;
            if (dn_tvalid !== 1'b1 || dn_tdata !== exp_b[c-1] || dn_tlast !== (c == 8)) begin
               failures++;
               $display("FAIL b2b_beat_c%0d: got valid=%b data=%h last=%b expected 1/%h/%b",
                        c, dn_tvalid, dn_tdata, dn_tlast, exp_b[c-1], (c == 8));
            end
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (dn_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: got dn_tvalid=%b expected 0", dn_tvalid);
      end
   endtask

   task automatic test_stall();
      logic [7:0] exp_b [7];
      logic       rdy_b [7];
      exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hDD};
      rdy_b = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      @(negedge clk);
      up_tdata  = 32'hDDCCBBAA;
      up_tlast  = 1'b0;
      up_tlanes = 2'd0;
      up_tvalid = 1'b1;
      dn_tready = 1'b1;
      #1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         up_tvalid = 1'b0;
         dn_tready = rdy_b[i];
         #1;
         checks++;
         if (dn_tvalid !== 1'b1 || dn_tdata !== exp_b[i] || dn_tlast !== 1'b0) begin
            failures++;
            $display("FAIL stall_c%0d: got valid=%b data=%h last=%b expected 1/%h/0",
                     i, dn_tvalid, dn_tdata, dn_tlast, exp_b[i]);
         end
         checks++;
         if (up_tready !== (i == 6)) begin
            failures++;
            $display("FAIL stall_ready_c%0d: got up_tready=%b expected %b", i, up_tready, (i == 6));
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (dn_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL stall_idle: got dn_tvalid=%b expected 0", dn_tvalid);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] exp_b [4];
      exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
      @(negedge clk);
      up_tdata  = 32'hDDCCBBAA;
      up_tlast  = 1'b0;
      up_tlanes = 2'd0;
      up_tvalid = 1'b1;
      dn_tready = 1'b1;
      #1;
      repeat (2) begin
         @(negedge clk);
         up_tvalid = 1'b0;
      end
      @(negedge clk);
      #1;
      checks++;
      if (dn_tvalid !== 1'b1 || dn_tdata !== 8'hCC) begin
         failures++;
         $display("FAIL areset_pre: got valid=%b data=%h expected 1/cc", dn_tvalid, dn_tdata);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (dn_tvalid !== 1'b0 || dn_tdata !== 8'h00 || dn_tlast !== 1'b0 || up_tready !== 1'b0) begin
         failures++;
         $display("FAIL areset_now: got valid=%b data=%h last=%b up_tready=%b expected 0/00/0/0",
                  dn_tvalid, dn_tdata, dn_tlast, up_tready);
      end
      @(negedge clk);
      rst       = 1'b0;
      up_tdata  = 32'h04030201;
      up_tlast  = 1'b1;
      up_tlanes = 2'd3;
      up_tvalid = 1'b1;
      #1;
      checks++;
      if (up_tready !== 1'b1 || dn_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL areset_idle: got up_tready=%b dn_tvalid=%b expected 1/0", up_tready, dn_tvalid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         up_tvalid = 1'b0;
         up_tlast  = 1'b0;
         #1;
         checks++;
         if (dn_tvalid !== 1'b1 || dn_tdata !== exp_b[i] || dn_tlast !== (i == 3)) begin
            failures++;
            $display("FAIL areset_beat%0d: got valid=%b data=%h last=%b expected 1/%h/%b",
                     i, dn_tvalid, dn_tdata, dn_tlast, exp_b[i], (i == 3));
         end
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_random();
      int         words_sent;
      int         cycles;
      int         up_last_cnt;
      int         dn_last_cnt;
      int         n;
      bit         accepted;
      logic [8:0] e;
      words_sent  = 0;
      cycles      = 0;
      up_last_cnt = 0;
      dn_last_cnt = 0;
      accepted    = 1'b0;
      exp_q.delete();
      while (((words_sent < 1000) || (exp_q.size() != 0)) && (cycles < 60000)) begin
         @(negedge clk);
         if (accepted) begin
            up_tvalid = 1'b0;
            accepted  = 1'b0;
         end
         // An offered word stays put until it is taken.
         if (!up_tvalid && (words_sent < 1000) && ($urandom_range(1, 0) == 1)) begin
            up_tdata  = $urandom;
            up_tlast  = ($urandom_range(3, 0) == 0);
            up_tlanes = 2'($urandom_range(3, 0));
            up_tvalid = 1'b1;
         end
         dn_tready = 1'($urandom_range(1, 0));
         #1;
         if (dn_tvalid && dn_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rand_extra_beat: got data=%h last=%b expected no beat", dn_tdata, dn_tlast);
            end else begin
               e = exp_q.pop_front();
               if ({dn_tlast, dn_tdata} !== e) begin
                  failures++;
                  $display("FAIL rand_beat: got last=%b data=%h expected last=%b data=%h",
                           dn_tlast, dn_tdata, e[8], e[7:0]);
               end
            end
            if (dn_tlast) dn_last_cnt++;
         end
         if (up_tvalid && up_tready) begin
            n = up_tlast ? (int'(up_tlanes) + 1) : 4;
            for (int k = 0; k < n; k++) begin
               exp_q.push_back({(up_tlast && (k == n - 1)), up_tdata[k*8 +: 8]});
            end
            if (up_tlast) up_last_cnt++;
            words_sent++;
            accepted = 1'b1;
         end
         cycles++;
      end
      @(negedge clk);
      up_tvalid = 1'b0;
      up_tlast  = 1'b0;
      checks++;
      if (cycles >= 60000) begin
         failures++;
         $display("FAIL rand_timeout: got words=%0d pending=%0d expected 1000/0", words_sent, exp_q.size());
      end
      checks++;
      if (dn_last_cnt != up_last_cnt) begin
         failures++;
         $display("FAIL rand_tlast_count: got %0d expected %0d", dn_last_cnt, up_last_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_back_to_back();
      test_stall();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
